// File: rtl/csr_trap_unit.sv
// -----------------------------------------------------------------------------
// csr_trap_unit
//
// Machine-mode CSR file with integrated trap / mret sequencing and interrupt
// synchronisation. Reads are served combinationally to id_stage; writes,
// trap entry and mret arrive from ex_stage and take effect at the next
// rising edge (no read/write bypass).
//
// Strobe semantics: csr_we, trap_valid, mret_valid and instret_inc are
// single-cycle qualifiers sampled at the rising edge of clk. The unit always
// accepts them (there is no ready/backpressure path). Within one cycle the
// priority is trap_valid > mret_valid > CSR write, resolved per field, so a
// lower-priority action only loses the fields the winner also updates.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   csr_raddr / csr_rdata      combinational read port
//   csr_rillegal               csr_raddr is not an implemented CSR
//   csr_we/waddr/wdata/op      read-modify-write port (00 wr, 01 set, 10 clr)
//   trap_valid/cause/pc/val    trap entry update of mepc/mcause/mtval/mstatus
//   mret_valid                 mret update of mstatus
//   instret_inc                minstret increment
//   irq_ext/irq_timer/irq_sw   asynchronous interrupt lines (2-flop sync)
//   trap_target                redirect PC for trap_cause (combinational)
//   mepc_out                   current mepc (mret target)
//   irq_req                    an enabled interrupt is pending and MIE=1
// -----------------------------------------------------------------------------
module csr_trap_unit #(
  parameter int          XLEN        = 32,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_rillegal,
  input  logic            csr_we,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [1:0]      csr_op,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_valid,
  input  logic            instret_inc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_out,
  output logic            irq_req
);

  // CSR addresses
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // Only MEIE/MTIE/MSIE are implemented in mie.
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             st_mie_q,  st_mie_d;
  logic             st_mpie_q, st_mpie_d;
  logic [31:0]      mie_q,     mie_d;
  logic [31:0]      mtvec_q,   mtvec_d;
  logic [31:0]      mepc_q,    mepc_d;
  logic [31:0]      mcause_q,  mcause_d;
  logic [31:0]      mtval_q,   mtval_d;
  logic [CNT_W-1:0] mcycle_q,  mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;

  // Interrupt synchroniser, bit order {ext, timer, sw}
  logic [2:0]       irq_meta_q;
  logic [2:0]       irq_sync_q;

  // ---------------------------------------------------------------------------
  // Architectural views of the registered state
  // ---------------------------------------------------------------------------
  logic [31:0] mstatus_w;
  logic [31:0] mip_w;
  logic [63:0] mcycle_ext;
  logic [63:0] minstret_ext;

  // MPP is hardwired to machine mode (2'b11).
  assign mstatus_w = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
  assign mip_w     = {20'b0, irq_sync_q[2], 3'b0, irq_sync_q[1], 3'b0,
                      irq_sync_q[0], 3'b0};

  // Zero-extend counters to 64 bits so the high-half read is uniform for
  // every legal CNT_W.
  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);

  function automatic logic [31:0] csr_value(input logic [11:0] addr);
    logic [31:0] v;
    v = 32'h0;
    case (addr)
      A_MSTATUS:   v = mstatus_w;
      A_MIE:       v = mie_q;
      A_MTVEC:     v = mtvec_q;
      A_MEPC:      v = mepc_q;
      A_MCAUSE:    v = mcause_q;
      A_MTVAL:     v = mtval_q;
      A_MIP:       v = mip_w;
      A_MCYCLE:    v = mcycle_ext[31:0];
      A_MCYCLEH:   v = mcycle_ext[63:32];
      A_MINSTRET:  v = minstret_ext[31:0];
      A_MINSTRETH: v = minstret_ext[63:32];
      A_MHARTID:   v = 32'(HART_ID);
      default:     v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic csr_illegal(input logic [11:0] addr);
    logic ill;
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH, A_MHARTID: ill = 1'b0;
      default:                                                 ill = 1'b1;
    endcase
    return ill;
  endfunction

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  assign csr_rdata    = csr_value(csr_raddr);
  assign csr_rillegal = csr_illegal(csr_raddr);

  // ---------------------------------------------------------------------------
  // Outputs derived from state
  // ---------------------------------------------------------------------------
  logic [31:0] tvec_base;
  logic [31:0] tvec_off;

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  // 4*cause[30:0] modulo 2^32; cause[31] shifts out and does not contribute.
  assign tvec_off  = trap_cause << 2;

  assign trap_target = (mtvec_q[1:0] == 2'b01 && trap_cause[31])
                       ? tvec_base + tvec_off
                       : tvec_base;

  assign mepc_out = mepc_q;
  assign irq_req  = st_mie_q & (|(mip_w & mie_q));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [31:0] csr_old;
  logic [31:0] csr_new;
  logic        csr_wr_en;

  always_comb begin
    csr_old = csr_value(csr_waddr);
    case (csr_op)
      OP_WRITE: csr_new = csr_wdata;
      OP_SET:   csr_new = csr_old | csr_wdata;
      OP_CLEAR: csr_new = csr_old & ~csr_wdata;
      default:  csr_new = csr_old;
    endcase
    csr_wr_en = csr_we && (csr_op != 2'b11) && !csr_illegal(csr_waddr);
  end

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = instret_inc ? minstret_q + CNT_W'(1) : minstret_q;

    // Lowest priority: CSR write. A write to one counter half replaces the
    // increment and holds the other half at its registered value.
    if (csr_wr_en) begin
      case (csr_waddr)
        A_MSTATUS: begin
          st_mie_d  = csr_new[3];
          st_mpie_d = csr_new[7];
        end
        A_MIE:       mie_d      = csr_new & MIE_MASK;
        // Reserved modes (1x) collapse to direct mode.
        A_MTVEC:     mtvec_d    = csr_new[1] ? {csr_new[31:2], 2'b00} : csr_new;
        A_MEPC:      mepc_d     = {csr_new[31:2], 2'b00};
        A_MCAUSE:    mcause_d   = csr_new;
        A_MTVAL:     mtval_d    = csr_new;
        A_MCYCLE:    mcycle_d   = {mcycle_q[CNT_W-1:32], csr_new};
        A_MCYCLEH:   mcycle_d   = {csr_new[CNT_W-33:0], mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[CNT_W-1:32], csr_new};
        A_MINSTRETH: minstret_d = {csr_new[CNT_W-33:0], minstret_q[31:0]};
        default: ;  // mip, mhartid: read-only
      endcase
    end

    // mret overrides only the mstatus interrupt-enable stack.
    if (mret_valid) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end

    // Trap entry has the final say on every field it touches.
    if (trap_valid) begin
      mepc_d    = {trap_pc[31:2], 2'b00};
      mcause_d  = trap_cause;
      mtval_d   = trap_val;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RESET;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      irq_meta_q <= 3'b000;
      irq_sync_q <= 3'b000;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      irq_meta_q <= {irq_ext, irq_timer, irq_sw};
      irq_sync_q <= irq_meta_q;
    end
  end

endmodule
